crop_frame_scheduler: RTL and testbench
=======================================

# crop_frame_scheduler

Frame-level controller placed between the pixel source and the crop + CNN pipeline (crop_plus_fifo feeding myproject). Each accepted frame request drives the CNN `ap_start` and admits exactly IN_ROWS×IN_COLS input pixels, no more. It then collects one result word from each of the five CNN output channels and presents them as a single result bundle. A per-frame watchdog flags a stalled pipeline.

## Interface
- PIXEL_BIT_WIDTH, 12, pixel and result word width
- IN_ROWS, 40, input frame rows
- IN_COLS, 40, input frame columns
- TIMEOUT_CYCLES, 65535, idle cycles allowed before the watchdog fires; minimum 2
- Clocking: one clock, `clk`. Reset is `reset`, asynchronous and active-high.
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous active-high reset
- frame_req_valid  in  1  request to process one frame
- frame_req_ready  out  1  request accepted when high together with valid
- src_TVALID  in  1  upstream pixel valid (data bypasses this block)
- src_TREADY  out  1  gated ready back to the source
- dut_TVALID  out  1  gated valid to crop input
- dut_TREADY  in  1  crop input ready
- ap_start  out  1  CNN start
- ap_done  in  1  CNN done pulse
- res_TDATA  in  5*PIXEL_BIT_WIDTH  CNN outputs; channel i occupies [i*W +: W]
- res_TVALID  in  5  per-channel output valid
- res_TREADY  out  5  per-channel output ready
- result_data  out  5*PIXEL_BIT_WIDTH  captured result bundle, same packing as res_TDATA
- result_valid  out  1  bundle valid
- result_ready  in  1  bundle consumed
- frame_count  out  16  completed frames; wraps from 65535 to 0
- timeout_err  out  1  sticky watchdog flag
- err_clear  in  1  clears timeout_err

## Operation
- States: IDLE, STREAM, DRAIN, REPORT.
- IDLE
  - frame_req_ready = 1.
  - On handshake: clear pix_cnt, the captured[4:0] mask, done_seen and the watchdog; go to STREAM.
- STREAM
  - ap_start = 1.
  - dut_TVALID = src_TVALID and src_TREADY = dut_TREADY, both combinational.
  - pix_cnt increments on each dut handshake.
  - The handshake with pix_cnt == IN_ROWS*IN_COLS−1 moves to DRAIN.
- Outside STREAM: dut_TVALID = 0 and src_TREADY = 0. The source is stalled and no extra pixel leaks.
- Output capture, in STREAM and DRAIN
  - res_TREADY[i] = ~captured[i].
  - On res_TVALID[i] & res_TREADY[i]: latch the slice into result_data and set captured[i]. A second word on an already-captured channel is back-pressured.
- ap_done: a pulse in STREAM or DRAIN sets done_seen. ap_start stays high until done_seen, then drops.
- DRAIN: go to REPORT when captured == 5'b11111 and done_seen are both true (including same-cycle sets).
- REPORT
  - result_valid = 1; result_data is held stable.
  - On result_ready: frame_count += 1 and go to IDLE.
- Watchdog
  - Counts cycles in STREAM and DRAIN.
  - Resets on any dut handshake, any res handshake, or ap_done.
  - On reaching TIMEOUT_CYCLES: set timeout_err and force IDLE. frame_count does not increment; partial results are discarded.
- timeout_err clears only on err_clear. If err_clear and a new timeout occur in the same cycle, set wins.
- pix_cnt width: $clog2(IN_ROWS*IN_COLS+1).

## Timing
- Reset values
  - State IDLE, so frame_req_ready = 1.
  - All other outputs are 0: ap_start, src_TREADY, dut_TVALID, res_TREADY, result_valid, result_data, frame_count, timeout_err.
- Reset asserted mid-frame: immediate return to IDLE. All counters and captures are cleared.
- Request accepted in cycle N:
  - ap_start = 1 and pixel gating open from cycle N+1.
  - Last-pixel handshake in cycle M: gating is closed from cycle M+1.
- DRAIN exit condition true in cycle K: result_valid = 1 from cycle K+1.
- REPORT handshake in cycle R: IDLE in R+1, so the next request is accepted no earlier than R+1. This gives a one-cycle bubble between frames.
- State, counters, result_data and timeout_err are registered. The gating and ready outputs are combinational from state plus the corresponding valid/ready.
- A CNN that outputs early is handled: results captured during STREAM are valid.

## Test plan
- Nominal frame: one request; 1600 pixels with dut_TREADY always 1; five results 0x001..0x005 plus ap_done. Expect:
  - exactly 1600 dut handshakes;
  - result_data = {0x005,0x004,0x003,0x002,0x001};
  - result_valid one cycle after the last capture;
  - frame_count = 1 after result_ready.
- Overrun guard: source holds src_TVALID = 1 continuously for 2000 cycles. Expect src_TREADY = 0 from the cycle after the 1600th handshake, with no 1601st handshake.
- Back-pressure and ordering: random dut_TREADY; channel 3 valid before channel 0; channel 3 presents a second word. Expect the second word held with res_TREADY[3] = 0 and only the first word captured.
- Result stall: hold result_ready = 0 for 50 cycles in REPORT. Expect result_valid and data stable, frame_req_ready = 0, and frame_count incremented only on the handshake.
- Watchdog: TIMEOUT_CYCLES = 100; stop pixels after 500. Expect:
  - timeout_err = 1 after 100 idle cycles;
  - return to IDLE with frame_count unchanged;
  - the flag persists until err_clear.
- Async reset mid-DRAIN with 3 channels captured. Expect all outputs at reset values immediately; the next frame then completes normally with frame_count = 1.

Source files
------------

// File: rtl/crop_frame_scheduler.sv
// Frame-level controller ahead of crop_plus_fifo/myproject: admits exactly one frame of pixels per
// request, sequences ap_start/ap_done, bundles the five CNN result words and watches for stalls.
module crop_frame_scheduler #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_req_valid,
  output logic                         frame_req_ready,
  input  logic                         src_TVALID,
  output logic                         src_TREADY,
  output logic                         dut_TVALID,
  input  logic                         dut_TREADY,
  output logic                         ap_start,
  input  logic                         ap_done,
  input  logic [5*PIXEL_BIT_WIDTH-1:0] res_TDATA,
  input  logic [4:0]                   res_TVALID,
  output logic [4:0]                   res_TREADY,
  output logic [5*PIXEL_BIT_WIDTH-1:0] result_data,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [15:0]                  frame_count,
  output logic                         timeout_err,
  input  logic                         err_clear
);

  localparam int NUM_CH    = 5;
  localparam int FRAME_PIX = IN_ROWS * IN_COLS;
  localparam int PIX_W     = $clog2(FRAME_PIX + 1);
  localparam int WD_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIX - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  logic [1:0]                   state_r;
  logic [1:0]                   state_nxt_s;
  logic [PIX_W-1:0]             pix_cnt_r;
  logic [NUM_CH-1:0]            captured_r;
  logic                         done_seen_r;
  logic [WD_W-1:0]              wd_cnt_r;
  logic [5*PIXEL_BIT_WIDTH-1:0] result_data_r;
  logic [15:0]                  frame_count_r;
  logic                         timeout_err_r;

  logic              in_stream_s;
  logic              in_active_s;
  logic              req_hs_s;
  logic              dut_hs_s;
  logic              last_pix_s;
  logic [NUM_CH-1:0] res_hs_s;
  logic              activity_s;
  logic              drain_done_s;
  logic              wd_fire_s;
  logic              report_hs_s;

  assign in_stream_s = (state_r == ST_STREAM);
  assign in_active_s = in_stream_s || (state_r == ST_DRAIN);

  // Gating and ready outputs are decoded from the registered state so the pixel path never
  // sees more than one frame, even when the source keeps valid asserted.
  assign frame_req_ready = (state_r == ST_IDLE);
  assign dut_TVALID      = in_stream_s && src_TVALID;
  assign src_TREADY      = in_stream_s && dut_TREADY;
  assign res_TREADY      = in_active_s ? ~captured_r : 5'b00000;
  assign ap_start        = in_active_s && !done_seen_r;
  assign result_valid    = (state_r == ST_REPORT);
  assign result_data     = result_data_r;
  assign frame_count     = frame_count_r;
  assign timeout_err     = timeout_err_r;

  assign req_hs_s    = frame_req_ready && frame_req_valid;
  assign dut_hs_s    = dut_TVALID && dut_TREADY;
  assign last_pix_s  = dut_hs_s && (pix_cnt_r == LAST_PIX);
  assign res_hs_s    = res_TVALID & res_TREADY;
  assign activity_s  = dut_hs_s || (|res_hs_s) || ap_done;
  assign report_hs_s = result_valid && result_ready;

  // Same-cycle captures and ap_done count toward leaving DRAIN.
  assign drain_done_s = (state_r == ST_DRAIN) && ((captured_r | res_hs_s) == 5'b11111)
                        && (done_seen_r || ap_done);
  assign wd_fire_s    = in_active_s && !activity_s && !drain_done_s && (wd_cnt_r == WD_LAST);

  // Next-state selection for the frame sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_hs_s) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (wd_fire_s) begin
          state_nxt_s = ST_IDLE;
        end else if (last_pix_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_nxt_s = ST_REPORT;
        end else if (wd_fire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_REPORT: begin
        if (result_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus per-frame pixel count, capture mask and done tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pix_cnt_r   <= '0;
      captured_r  <= '0;
      done_seen_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (req_hs_s) begin
        pix_cnt_r   <= '0;
        captured_r  <= '0;
        done_seen_r <= 1'b0;
      end else begin
        if (dut_hs_s) begin
          pix_cnt_r <= pix_cnt_r + PIX_W'(1);
        end
        if (in_active_s) begin
          captured_r <= captured_r | res_hs_s;
          if (ap_done) begin
            done_seen_r <= 1'b1;
          end
        end
      end
    end
  end

  // Watchdog: counts consecutive cycles without any pipeline progress while a frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= '0;
    end else if (!in_active_s || wd_fire_s || activity_s) begin
      wd_cnt_r <= '0;
    end else begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end
  end

  // Result capture: each channel keeps its first word until the next frame overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_data_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (res_hs_s[i]) begin
          result_data_r[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] <=
            res_TDATA[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
        end
      end
    end
  end

  // Completed-frame counter and sticky timeout flag; a new timeout beats err_clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_r <= 16'd0;
      timeout_err_r <= 1'b0;
    end else begin
      if (report_hs_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
      if (wd_fire_s) begin
        timeout_err_r <= 1'b1;
      end else if (err_clear) begin
        timeout_err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crop_frame_scheduler.sv
// Randomized scoreboard bench for crop_frame_scheduler: stimulus queues expected bundles,
// an independent negedge monitor checks pixel admission, result bundles and frame counting.
module tb_crop_frame_scheduler;

  localparam int W       = 12;
  localparam int NPIX    = 40 * 40;
  localparam int TIMEOUT = 100;

  logic         clk;
  logic         reset;
  logic         frame_req_valid;
  logic         frame_req_ready;
  logic         src_TVALID;
  logic         src_TREADY;
  logic         dut_TVALID;
  logic         dut_TREADY;
  logic         ap_start;
  logic         ap_done;
  logic [5*W-1:0] res_TDATA;
  logic [4:0]   res_TVALID;
  logic [4:0]   res_TREADY;
  logic [5*W-1:0] result_data;
  logic         result_valid;
  logic         result_ready;
  logic [15:0]  frame_count;
  logic         timeout_err;
  logic         err_clear;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [5*W-1:0] exp_q[$];
  logic [15:0]    exp_fc;
  int             frame_hs;
  bit             gate_pend;

  // pixel source controls
  bit pix_on    = 1'b0;
  bit pix_rand  = 1'b0;
  bit rdy_rand  = 1'b0;
  int pix_limit = 1000000;

  crop_frame_scheduler #(
    .PIXEL_BIT_WIDTH(W),
    .IN_ROWS(40),
    .IN_COLS(40),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_req_valid(frame_req_valid),
    .frame_req_ready(frame_req_ready),
    .src_TVALID(src_TVALID),
    .src_TREADY(src_TREADY),
    .dut_TVALID(dut_TVALID),
    .dut_TREADY(dut_TREADY),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .res_TDATA(res_TDATA),
    .res_TVALID(res_TVALID),
    .res_TREADY(res_TREADY),
    .result_data(result_data),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .frame_count(frame_count),
    .timeout_err(timeout_err),
    .err_clear(err_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pixel source: holds valid (or random valid) until the per-frame limit is reached.
  initial begin
    src_TVALID = 1'b0;
    dut_TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pix_on && frame_hs < pix_limit) begin
        src_TVALID = pix_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        src_TVALID = 1'b0;
      end
      dut_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pixel admission, gating after the last pixel, bundle scoreboard, frame counter.
  initial begin
    exp_fc    = 16'd0;
    frame_hs  = 0;
    gate_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_fc    = 16'd0;
        frame_hs  = 0;
        gate_pend = 1'b0;
        exp_q.delete();
      end else begin
        if (gate_pend) begin
          check("gate_closed", 64'({src_TREADY, dut_TVALID}), 64'(2'b00));
          gate_pend = 1'b0;
        end
        check("frame_count", 64'(frame_count), 64'(exp_fc));
        if (frame_req_valid && frame_req_ready) frame_hs = 0;
        if (dut_TVALID && dut_TREADY) begin
          if (frame_hs >= NPIX) check("overrun", 64'(frame_hs + 1), 64'(NPIX));
          frame_hs++;
          if (frame_hs == NPIX) gate_pend = 1'b1;
        end
        if (result_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(1), 64'(0));
          end else begin
            check("result_data", 64'(result_data), 64'(exp_q[0]));
            if (result_ready) begin
              check("pixels_per_frame", 64'(frame_hs), 64'(NPIX));
              void'(exp_q.pop_front());
              exp_fc = exp_fc + 16'd1;
            end
          end
        end
      end
    end
  end

  task automatic req_frame();
    int n = 0;
    frame_req_valid = 1'b1;
    while (!frame_req_ready && n < 50) begin
      step();
      n++;
    end
    check("req_accept", 64'(frame_req_ready), 64'(1));
    step();
    frame_req_valid = 1'b0;
    check("ap_start_on", 64'(ap_start), 64'(1));
  endtask

  task automatic wait_pixels(input int n);
    int t = 0;
    while (frame_hs < n && t < 30000) begin
      step();
      t++;
    end
    check("pixels_reached", 64'(frame_hs), 64'(n));
  endtask

  task automatic pulse_done();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
  endtask

  task automatic send_word(input int ch, input logic [W-1:0] val, output logic rv);
    int n = 0;
    bit got = 1'b0;
    rv = 1'b0;
    res_TDATA[ch*W +: W] = val;
    res_TVALID[ch] = 1'b1;
    while (!got && n < 500) begin
      @(negedge clk);
      got = res_TREADY[ch];
      rv  = result_valid;
      n++;
      step();
    end
    res_TVALID[ch] = 1'b0;
    check("res_handshake", 64'(got), 64'(1));
  endtask

  task automatic take_result(input int stall);
    int n = 0;
    logic [5*W-1:0] snap;
    while (!result_valid && n < 500) begin
      step();
      n++;
    end
    check("result_valid_up", 64'(result_valid), 64'(1));
    snap = result_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({result_valid, frame_req_ready, result_data}), 64'({1'b1, 1'b0, snap}));
      step();
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({frame_req_ready, ap_start, src_TREADY, dut_TVALID, res_TREADY, result_valid, timeout_err}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0}));
    check({name, "_data"}, 64'({frame_count, result_data}), 64'(0));
  endtask

  // One complete randomized frame with results delivered after the stream in random order.
  task automatic random_frame(input int stall);
    logic [W-1:0] v[5];
    int ord[5];
    int j;
    int t;
    logic rv;
    for (int i = 0; i < 5; i++) begin
      v[i] = W'($urandom_range(0, 4095));
      ord[i] = i;
    end
    for (int i = 4; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = ord[i];
      ord[i] = ord[j];
      ord[j] = t;
    end
    exp_q.push_back({v[4], v[3], v[2], v[1], v[0]});
    pix_rand = 1'($urandom_range(0, 1));
    rdy_rand = 1'($urandom_range(0, 1));
    req_frame();
    wait_pixels(NPIX);
    for (int i = 0; i < 5; i++) begin
      send_word(ord[i], v[ord[i]], rv);
      if (i == 2) pulse_done();
    end
    take_result(stall);
  endtask

  initial begin
    logic rv;
    logic [W-1:0] v[5];
    reset = 1'b1;
    frame_req_valid = 1'b0;
    ap_done = 1'b0;
    res_TDATA = '0;
    res_TVALID = 5'b00000;
    result_ready = 1'b0;
    err_clear = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset_values");
    reset = 1'b0;
    step();

    // Nominal frame with source valid held continuously for ~2000 cycles
    pix_on = 1'b1; pix_rand = 1'b0; rdy_rand = 1'b0;
    exp_q.push_back({12'h005, 12'h004, 12'h003, 12'h002, 12'h001});
    req_frame();
    wait_pixels(NPIX);
    check("ap_start_drain", 64'(ap_start), 64'(1));
    for (int i = 0; i < 8; i++) begin
      repeat (49) step();
      pulse_done();
    end
    check("ap_start_dropped", 64'(ap_start), 64'(0));
    for (int i = 0; i < 5; i++) begin
      send_word(i, W'(i + 1), rv);
    end
    check("rv_not_early", 64'(rv), 64'(0));
    check("rv_next_cycle", 64'(result_valid), 64'(1));
    take_result(0);
    check("fc_nominal", 64'(frame_count), 64'(1));

    // Back-pressure, early out-of-order capture, duplicate word on channel 3, result stall
    pix_rand = 1'b1; rdy_rand = 1'b1;
    for (int i = 0; i < 5; i++) v[i] = W'($urandom_range(0, 4095));
    exp_q.push_back({v[4], v[3], v[2], v[1], v[0]});
    req_frame();
    repeat (20) step();
    send_word(3, v[3], rv);
    res_TDATA[3*W +: W] = ~v[3];
    res_TVALID[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ch3_backpressure", 64'(res_TREADY[3]), 64'(0));
      step();
    end
    res_TVALID[3] = 1'b0;
    wait_pixels(NPIX);
    send_word(0, v[0], rv);
    send_word(1, v[1], rv);
    send_word(2, v[2], rv);
    send_word(4, v[4], rv);
    pulse_done();
    take_result(50);

    // Watchdog: pixels stop after 500, no results
    pix_rand = 1'b0; rdy_rand = 1'b0; pix_limit = 500;
    req_frame();
    wait_pixels(500);
    for (int j = 1; j <= TIMEOUT + 1; j++) begin
      check("watchdog_timing", 64'(timeout_err), 64'(j == TIMEOUT + 1));
      if (j <= TIMEOUT) step();
    end
    check("watchdog_idle", 64'({frame_req_ready, ap_start, src_TREADY}), 64'(3'b100));
    repeat (20) step();
    check("timeout_sticky", 64'(timeout_err), 64'(1));
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("timeout_cleared", 64'(timeout_err), 64'(0));
    pix_limit = 1000000;

    // Asynchronous reset in DRAIN with three channels captured
    req_frame();
    wait_pixels(NPIX);
    send_word(0, 12'h0aa, rv);
    send_word(1, 12'h0bb, rv);
    send_word(2, 12'h0cc, rv);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    step();
    step();
    reset = 1'b0;
    step();

    random_frame(0);
    check("fc_after_reset", 64'(frame_count), 64'(1));
    random_frame(int'($urandom_range(0, 5)));
    random_frame(int'($urandom_range(0, 5)));
    pix_on = 1'b0;
    repeat (5) step();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
